// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter slice.
// Provides the operation encodings carried on in_type, the controller state
// enum, the shift-amount width helper and a legality check for op codes.
package shifter_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROL = 3'b011,
        SH_ROR = 3'b100
    } sh_type_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Number of shift-amount bits that matter for an xlen-bit operand
    function automatic int shw(input int xlen);
        return $clog2(xlen);
    endfunction

    // Rotates are only legal when the rotate datapath is enabled
    function automatic logic type_legal(input logic [2:0] t, input logic rot_en);
        logic ok;
        ok = 1'b0;
        case (t)
            SH_SLL, SH_SRL, SH_SRA: ok = 1'b1;
            SH_ROL, SH_ROR:         ok = rot_en;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One combinational shift step of the iterative shifter.
// Ports:
//   data     - operand being shifted
//   amt      - shift distance for this step, 0..STEP
//   sh_type  - operation code (SLL/SRL/SRA/ROL/ROR), unknown codes give 0
//   result   - shifted operand
module alu_shift_step
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic [XLEN-1:0]            data,
    input  logic [$clog2(STEP+1)-1:0]  amt,
    input  logic [2:0]                 sh_type,
    output logic [XLEN-1:0]            result
);

    logic [2*XLEN-1:0] dbl;

    // Rotates shift a doubled copy of the operand so wrapped bits appear
    // in the kept half without needing an XLEN-amt subtraction
    always_comb begin
        dbl    = {data, data};
        result = '0;
        case (sh_type)
            SH_SLL:  result = data << amt;
            SH_SRL:  result = data >> amt;
            SH_SRA:  result = $signed(data) >>> amt;
            SH_ROL: begin
                dbl    = dbl << amt;
                result = dbl[2*XLEN-1:XLEN];
            end
            SH_ROR: begin
                dbl    = dbl >> amt;
                result = dbl[XLEN-1:0];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_shifter_iter.sv
// Multi-cycle shifter/rotator with valid/ready handshakes and flush.
// Shifts by up to STEP bit positions per cycle until the latched amount is
// used up, then holds the result until the consumer takes it.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   flush                 - synchronous abort of any in-flight operation
//   in_valid/in_ready     - request handshake; in_data, in_shamt, in_type
//   out_valid/out_ready   - result handshake; out_data
//   busy                  - controller is not idle
module alu_shifter_iter
    import shifter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STEP       = 1,
    parameter int ENABLE_ROT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [XLEN-1:0] in_shamt,
    input  logic [2:0]      in_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    localparam int SHW = shw(XLEN);
    localparam int AW  = $clog2(STEP + 1);

    state_e          state;
    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  remaining;
    logic [2:0]      type_q;
    logic [AW-1:0]   step_amt;
    logic [XLEN-1:0] step_out;
    logic            shamt_unused;

    // Only the low SHW bits of the amount are meaningful
    assign shamt_unused = ^in_shamt[XLEN-1:SHW];

    assign in_ready = !rst && (state == IDLE) && !flush;
    assign busy     = (state != IDLE);

    // Distance for this cycle: min(STEP, remaining)
    always_comb begin
        step_amt = '0;
        if (int'(remaining) >= STEP) step_amt = AW'(STEP);
        else                         step_amt = AW'(remaining);
    end

    alu_shift_step #(
        .XLEN(XLEN),
        .STEP(STEP)
    ) u_step (
        .data    (data_q),
        .amt     (step_amt),
        .sh_type (type_q),
        .result  (step_out)
    );

    // Controller and datapath registers. Illegal ops are latched with zero
    // data and zero amount so they complete with the shamt=0 latency and
    // a zero result through the normal path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            remaining <= '0;
            type_q    <= SH_SLL;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            remaining <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        type_q <= in_type;
                        if (type_legal(in_type, ENABLE_ROT != 0)) begin
                            data_q    <= in_data;
                            remaining <= in_shamt[SHW-1:0];
                        end else begin
                            data_q    <= '0;
                            remaining <= '0;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (remaining == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= data_q;
                    end else begin
                        data_q    <= step_out;
                        remaining <= remaining - SHW'(step_amt);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
